// File: rtl/jt900h_div_pkg.sv
// Definitions shared by the JT900H CPU datapath blocks (divider, ALU):
// operand-width encoding and the latched division request.
package jt900h_div_pkg;

    // Width selector encoding used by DIV/DIVS and the ALU; any other value means word
    localparam logic [1:0] W_BYTE = 2'b01;

    function automatic logic is_byte(input logic [1:0] w);
        return w == W_BYTE;
    endfunction

    typedef struct packed {
        logic        sign;
        logic        byte_mode;
        logic [31:0] op0;
        logic [15:0] op1;
    } div_req_t;

endpackage

// File: rtl/jt900h_div_if.sv
// Request/response bundle between the JT900H sequencer and the divider.
interface jt900h_div_if;
    logic        start;
    logic        sign;
    logic [1:0]  w;
    logic [31:0] op0;
    logic [15:0] op1;
    logic        busy;
    logic        done;
    logic [31:0] rslt;
    logic        v;

    modport master (
        output start, sign, w, op0, op1,
        input  busy, done, rslt, v
    );

    modport slave (
        input  start, sign, w, op0, op1,
        output busy, done, rslt, v
    );
endinterface

// File: rtl/jt900h_div_step.sv
// One restoring division step: shift in a dividend bit, trial-subtract the
// divisor and keep the difference only when it did not borrow.
module jt900h_div_step (
    input  logic [15:0] rem,
    input  logic        din,
    input  logic [15:0] dsor,
    output logic [15:0] rem_nx,
    output logic        qbit
);
    logic [16:0] trial;
    logic [17:0] diff;

    // One bit wider than the shifted remainder so the borrow is never lost
    assign trial  = {rem, din};
    assign diff   = {1'b0, trial} - {2'b00, dsor};
    assign qbit   = ~diff[17];
    assign rem_nx = qbit ? diff[15:0] : trial[15:0];
endmodule

// File: rtl/jt900h_div.sv
// Sequential restoring divider for the TLCS-900H DIV/DIVS instructions.
// Byte mode divides 16/8, word mode 32/16, one quotient bit per enabled cycle.
module jt900h_div
    import jt900h_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    jt900h_div_if.slave bus
);
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PREP = 3'd1;
    localparam logic [2:0] ST_ITER = 3'd2;
    localparam logic [2:0] ST_FIX  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam int BYTE_N = 8;
    localparam int WORD_N = 16;

    localparam logic [7:0]  BYTE_QLIM = 8'(1 << (BYTE_N - 1));
    localparam logic [15:0] WORD_QLIM = 16'(1 << (WORD_N - 1));

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        PREP = ST_PREP,
        ITER = ST_ITER,
        FIX  = ST_FIX,
        DONE = ST_DONE
    } state_t;

    state_t      state;
    div_req_t    req;
    logic [4:0]  cnt;
    logic [15:0] rem;
    logic [15:0] dq;
    logic [15:0] dsor;
    logic        qneg;
    logic        rneg;
    logic        big;

    logic        dd_neg;
    logic        dv_neg;
    logic [15:0] dd_hi;
    logic [15:0] dd_lo;
    logic [15:0] dv_mag;
    logic [15:0] m16;
    logic [31:0] m32;
    logic [7:0]  m8;

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        dd_neg = 1'b0;
        dv_neg = 1'b0;
        dd_hi  = '0;
        dd_lo  = '0;
        dv_mag = '0;
        m16    = req.op0[15:0];
        m32    = req.op0;
        m8     = req.op1[7:0];
        if (req.byte_mode) begin
            dd_neg = req.sign & req.op0[15];
            dv_neg = req.sign & req.op1[7];
            m16    = dd_neg ? ~req.op0[15:0] + 16'd1 : req.op0[15:0];
            m8     = dv_neg ? ~req.op1[7:0] + 8'd1 : req.op1[7:0];
            dd_hi  = {8'h00, m16[15:8]};
            dd_lo  = {m16[7:0], 8'h00};
            dv_mag = {8'h00, m8};
        end else begin
            dd_neg = req.sign & req.op0[31];
            dv_neg = req.sign & req.op1[15];
            m32    = dd_neg ? ~req.op0 + 32'd1 : req.op0;
            dd_hi  = m32[31:16];
            dd_lo  = m32[15:0];
            dv_mag = dv_neg ? ~req.op1 + 16'd1 : req.op1;
        end
    end

    logic [15:0] rem_nx;
    logic        qbit;
    logic [4:0]  last_step;

    jt900h_div_step u_step (
        .rem    (rem),
        .din    (dq[15]),
        .dsor   (dsor),
        .rem_nx (rem_nx),
        .qbit   (qbit)
    );

    assign last_step = req.byte_mode ? 5'(BYTE_N - 1) : 5'(WORD_N - 1);

    // Sign fix-up and signed range check on the finished magnitudes
    logic [15:0] qm;
    logic [15:0] rm;
    logic [15:0] qv;
    logic [15:0] rv;
    logic        fix_ovf;
    logic [31:0] fix_rslt;

    always_comb begin
        qm = req.byte_mode ? {8'h00, dq[7:0]}  : dq;
        rm = req.byte_mode ? {8'h00, rem[7:0]} : rem;
        qv = qneg ? ~qm + 16'd1 : qm;
        rv = rneg ? ~rm + 16'd1 : rm;
        if (req.byte_mode)
            fix_ovf = req.sign & (big | (qneg ? (qm[7:0] > BYTE_QLIM) : qm[7]));
        else
            fix_ovf = req.sign & (big | (qneg ? (qm > WORD_QLIM) : qm[15]));
        fix_rslt = req.byte_mode ? {req.op0[31:16], rv[7:0], qv[7:0]} : {rv, qv};
    end

    // PREP spends two cycles: the first latches magnitudes and signs, the second
    // checks them. Signed quotients too large for N bits are not trapped here but
    // carried in 'big' and reported by FIX, so every signed overflow has the same
    // latency as a normal division.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: datapath registers are reset as well, so outputs come up as zero.
        if (!rst) begin
            state    <= IDLE;
            req      <= '0;
            cnt      <= '0;
            rem      <= '0;
            dq       <= '0;
            dsor     <= '0;
            qneg     <= 1'b0;
            rneg     <= 1'b0;
            big      <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.v    <= 1'b0;
            bus.rslt <= '0;
        end else if (cen) begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        req.sign      <= bus.sign;
                        req.byte_mode <= is_byte(bus.w);
                        req.op0       <= bus.op0;
                        req.op1       <= bus.op1;
                        cnt           <= '0;
                        bus.busy      <= 1'b1;
                        state         <= PREP;
                    end
                end
                PREP: begin
                    if (cnt == 5'd0) begin
                        rem  <= dd_hi;
                        dq   <= dd_lo;
                        dsor <= dv_mag;
                        qneg <= dd_neg ^ dv_neg;
                        rneg <= dd_neg;
                        cnt  <= 5'd1;
                    end else begin
                        cnt <= '0;
                        big <= (rem >= dsor);
                        if (dsor == 16'd0 || (!req.sign && rem >= dsor)) begin
                            bus.v    <= 1'b1;
                            bus.rslt <= req.op0;
                            bus.done <= 1'b1;
                            state    <= DONE;
                        end else begin
                            state <= ITER;
                        end
                    end
                end
                ITER: begin
                    rem <= rem_nx;
                    dq  <= {dq[14:0], qbit};
                    cnt <= cnt + 5'd1;
                    if (cnt == last_step) state <= FIX;
                end
                FIX: begin
                    bus.v    <= fix_ovf;
                    bus.rslt <= fix_ovf ? req.op0 : fix_rslt;
                    bus.done <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jt900h_div.sv
// Randomised bench for jt900h_div: results, flags and latency are compared
// against an integer-arithmetic model of DIV/DIVS.
module tb_jt900h_div;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cen = 1'b0;
    int   checks = 0;
    int   errors = 0;

    jt900h_div_if bus();

    jt900h_div dut (
        .clk (clk),
        .rst (rst),
        .cen (cen),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: plain truncating integer division on the decoded operands
    function automatic void model(input logic s, input logic [1:0] wv, input logic [31:0] a,
                                  input logic [15:0] b, output logic [31:0] r,
                                  output logic vv, output int lat);
        bit     byt;
        int     n;
        longint da, db, q, rm, lim;
        byt = (wv == 2'b01);
        n   = byt ? 8 : 16;
        if (byt) begin
            da = s ? longint'($signed(a[15:0])) : longint'(a[15:0]);
            db = s ? longint'($signed(b[7:0]))  : longint'(b[7:0]);
        end else begin
            da = s ? longint'($signed(a)) : longint'(a);
            db = s ? longint'($signed(b)) : longint'(b);
        end
        r   = a;
        vv  = 1'b1;
        lat = 2;
        if (db == 0) return;
        q   = da / db;
        rm  = da % db;
        lim = 1;
        lim = lim << n;
        if (!s) begin
            if (q >= lim) return;
        end else begin
            lat = n + 3;
            if (q > lim / 2 - 1 || q < -(lim / 2)) return;
        end
        vv  = 1'b0;
        lat = n + 3;
        r   = byt ? {a[31:16], rm[7:0], q[7:0]} : {rm[15:0], q[15:0]};
    endfunction

    task automatic do_div(input logic s, input logic [1:0] wv, input logic [31:0] a,
                          input logic [15:0] b, input bit rnd_cen, input bit hold);
        logic [31:0] er;
        logic        ev;
        int          el;
        int          edges;
        bit          seen;
        model(s, wv, a, b, er, ev, el);
        @(negedge clk);
        cen       = 1'b1;
        bus.start = 1'b1;
        bus.sign  = s;
        bus.w     = wv;
        bus.op0   = a;
        bus.op1   = b;
        @(posedge clk);
        @(negedge clk);
        check("accept_busy", 32'(bus.busy), 32'd1);
        // Operands must have been latched: scramble the inputs
        bus.start = hold;
        bus.sign  = ~s;
        bus.w     = ~wv;
        bus.op0   = $urandom;
        bus.op1   = 16'($urandom);
        edges = 0;
        seen  = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            cen = rnd_cen ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(posedge clk);
            if (cen) edges++;
            @(negedge clk);
        end
        check("done_seen", 32'(seen), 32'd1);
        check("latency", 32'(edges), 32'(el));
        check("rslt", bus.rslt, er);
        check("v", 32'(bus.v), 32'(ev));
        check("busy_in_done", 32'(bus.busy), 32'd1);
        if (rnd_cen) begin
            cen = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check("done_hold_gated", 32'(bus.done), 32'd1);
        end
        cen = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("done_pulse", 32'(bus.done), 32'd0);
        check("busy_drop", 32'(bus.busy), 32'd0);
        check("rslt_held", bus.rslt, er);
        if (hold) begin
            bus.start = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check("one_division", 32'(bus.busy), 32'd0);
        end
        bus.start = 1'b0;
    endtask

    task automatic reset_mid_op();
        bit saw;
        @(negedge clk);
        cen       = 1'b1;
        bus.start = 1'b1;
        bus.sign  = 1'b0;
        bus.w     = 2'b10;
        bus.op0   = 32'h0001_2345;
        bus.op1   = 16'h0100;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_v", 32'(bus.v), 32'd0);
        check("rst_rslt", bus.rslt, 32'd0);
        saw = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) saw = 1'b1;
        end
        rst = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) saw = 1'b1;
        end
        check("no_done_after_reset", 32'(saw), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        s;
        logic [1:0]  wv;
        logic [31:0] a;
        logic [15:0] b;
        bus.start = 1'b0;
        bus.sign  = 1'b0;
        bus.w     = 2'b10;
        bus.op0   = '0;
        bus.op1   = '0;
        repeat (3) begin
            @(negedge clk);
            cen = 1'($urandom_range(0, 1));
        end
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_v", 32'(bus.v), 32'd0);
        check("reset_rslt", bus.rslt, 32'd0);
        cen = 1'b0;
        rst = 1'b1;

        do_div(1'b0, 2'b01, 32'h0000_0107, 16'h0010, 1'b0, 1'b0);
        do_div(1'b0, 2'b10, 32'h0001_2345, 16'h0100, 1'b0, 1'b0);
        do_div(1'b1, 2'b01, 32'h0000_FFF9, 16'h0002, 1'b0, 1'b0);
        do_div(1'b0, 2'b00, 32'hDEAD_BEEF, 16'h0000, 1'b0, 1'b0);
        do_div(1'b1, 2'b01, 32'h0000_1234, 16'hFF00, 1'b0, 1'b0);
        do_div(1'b0, 2'b01, 32'h0000_0200, 16'h0002, 1'b0, 1'b0);
        do_div(1'b1, 2'b10, 32'h8000_0000, 16'hFFFF, 1'b0, 1'b0);
        do_div(1'b1, 2'b01, 32'h1234_8000, 16'h00FF, 1'b0, 1'b0);
        do_div(1'b1, 2'b01, 32'h5555_FF80, 16'h0001, 1'b0, 1'b0);
        do_div(1'b1, 2'b11, 32'hFFFF_8000, 16'h0001, 1'b0, 1'b0);
        do_div(1'b1, 2'b10, 32'h0000_8000, 16'h0001, 1'b0, 1'b0);
        do_div(1'b0, 2'b10, 32'hFFFE_FFFF, 16'hFFFF, 1'b0, 1'b0);
        do_div(1'b0, 2'b01, 32'hABCD_00FF, 16'h00FF, 1'b1, 1'b0);
        do_div(1'b0, 2'b10, 32'h0000_FFFF, 16'h0003, 1'b0, 1'b1);

        for (int k = 0; k < 40; k++) begin
            s  = 1'($urandom_range(0, 1));
            wv = 2'($urandom_range(0, 3));
            a  = $urandom >> $urandom_range(0, 31);
            b  = 16'($urandom >> $urandom_range(16, 31));
            if (s && $urandom_range(0, 1) == 1) a = -a;
            if (s && $urandom_range(0, 1) == 1) b = -b;
            if (wv == 2'b01) a[31:16] = 16'($urandom);
            do_div(s, wv, a, b, 1'b1, (k % 5) == 0);
        end

        do_div(1'b0, 2'b00, 32'hCAFE_0001, 16'h0000, 1'b0, 1'b0);
        reset_mid_op();
        do_div(1'b1, 2'b10, 32'hFFFE_DCBB, 16'h0100, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
